// File: rtl/psum_pkg.sv
// Shared types and constants for the psum accumulate controller and its address counter.
package psum_pkg;

  localparam int DEF_MEM_DEPTH  = 24;
  localparam int DEF_DATA_WIDTH = 16;

  localparam logic [DEF_DATA_WIDTH-1:0] PSUM_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic [DEF_DATA_WIDTH-1:0] PSUM_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/psum_addr_cnt.sv
// Entry address counter wrapping at the latched length, plus pass counter and terminal-count flags.
module psum_addr_cnt #(
  parameter int ADDR_WIDTH = 5,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] len_m1,
  input  logic [PASS_WIDTH-1:0] pass_m1,
  input  logic                  step,
  input  logic                  count_pass,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [PASS_WIDTH-1:0] pass,
  output logic                  addr_last,
  output logic                  pass_last
);

  logic [ADDR_WIDTH-1:0] len_m1_q;
  logic [PASS_WIDTH-1:0] pass_m1_q;

  assign addr_last = (addr == len_m1_q);
  assign pass_last = (pass == pass_m1_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_m1_q  <= '0;
      pass_m1_q <= '0;
      addr      <= '0;
      pass      <= '0;
    end else if (load) begin
      len_m1_q  <= len_m1;
      pass_m1_q <= pass_m1;
      addr      <= '0;
      pass      <= '0;
    end else if (step) begin
      if (addr_last) begin
        addr <= '0;
        if (count_pass && !pass_last) pass <= pass + 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_acc_ctrl.sv
// Psum spad read-modify-write controller: accumulate products over passes, then drain.
// Define PSUM_ACC_SAT_EN for a signed saturating accumulate; default is wrap-around.
module psum_acc_ctrl
  import psum_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_len_m1,
  input  logic [PASS_WIDTH-1:0] cfg_pass_m1,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [DATA_WIDTH-1:0] prod_data,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [DATA_WIDTH-1:0] psum_out_data,
  output logic                  spad_w_en,
  output logic [ADDR_WIDTH-1:0] spad_w_addr,
  output logic [DATA_WIDTH-1:0] spad_din,
  output logic [ADDR_WIDTH-1:0] spad_r_addr,
  input  logic [DATA_WIDTH-1:0] spad_dout,
  output logic                  busy,
  output logic                  done
);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [PASS_WIDTH-1:0] pass;
  logic                  addr_last, pass_last;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] acc_base, sum;

  psum_addr_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PASS_WIDTH(PASS_WIDTH)
  ) u_addr_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      ((state == IDLE) && start),
    .len_m1    (cfg_len_m1),
    .pass_m1   (cfg_pass_m1),
    .step      (((state == ACCUM) && prod_valid) || ((state == DRAIN) && psum_out_ready)),
    .count_pass(state == ACCUM),
    .addr      (addr),
    .pass      (pass),
    .addr_last (addr_last),
    .pass_last (pass_last)
  );

  // The spad read completes on the negedge, so spad_dout already holds this entry's psum.
  assign acc_base = (pass == '0) ? '0 : spad_dout;

`ifdef PSUM_ACC_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH:0] sum_ext;
  assign sum_ext = {acc_base[DATA_WIDTH-1], acc_base} + {prod_data[DATA_WIDTH-1], prod_data};
  assign sum = (sum_ext[DATA_WIDTH] == sum_ext[DATA_WIDTH-1]) ? sum_ext[DATA_WIDTH-1:0] :
               (sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX);
`else
  assign sum = acc_base + prod_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (state == DRAIN) && psum_out_ready && addr_last;
    end
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (prod_valid && addr_last && pass_last) next_state = DRAIN;
      DRAIN:   if (psum_out_ready && addr_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    prod_ready     = 1'b0;
    psum_out_valid = 1'b0;
    spad_w_en      = 1'b0;
    spad_w_addr    = '0;
    spad_din       = '0;
    spad_r_addr    = '0;
    case (state)
      ACCUM: begin
        prod_ready  = 1'b1;
        spad_w_en   = prod_valid;
        spad_w_addr = addr;
        spad_r_addr = addr;
        spad_din    = sum;
      end
      DRAIN: begin
        psum_out_valid = 1'b1;
        spad_r_addr    = addr;
      end
      default: ;
    endcase
  end

  assign psum_out_data = spad_dout;
  assign busy          = (state != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl with a behavioural negedge-read spad model.
module tb_psum_acc_ctrl;
  import psum_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_len_m1;
  logic [PW-1:0] cfg_pass_m1;
  logic          prod_valid, prod_ready;
  logic [DW-1:0] prod_data;
  logic          psum_out_valid, psum_out_ready;
  logic [DW-1:0] psum_out_data;
  logic          spad_w_en;
  logic [AW-1:0] spad_w_addr, spad_r_addr;
  logic [DW-1:0] spad_din, spad_dout;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  psum_acc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len_m1(cfg_len_m1), .cfg_pass_m1(cfg_pass_m1),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out_data(psum_out_data),
    .spad_w_en(spad_w_en), .spad_w_addr(spad_w_addr), .spad_din(spad_din),
    .spad_r_addr(spad_r_addr), .spad_dout(spad_dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Spad model: posedge write, negedge read.
  logic [DW-1:0] spad_mem [32];
  logic          scramble = 1'b1;
  always @(posedge clk) begin
    if (spad_w_en) spad_mem[spad_w_addr] <= spad_din;
    else if (scramble) for (int i = 0; i < 32; i++) spad_mem[i] <= 16'($urandom);
  end
  always @(negedge clk) spad_dout <= spad_mem[spad_r_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference accumulate: one signed add per product, clamped or wrapped.
  function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_ACC_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[DW-1:0];
  endfunction

  logic [DW-1:0] job_prods [$];
  logic [DW-1:0] job_exp   [$];

  task automatic check_all_zero(input string tag);
    check({tag, "_prod_ready"}, prod_ready, 0);
    check({tag, "_out_valid"}, psum_out_valid, 0);
    check({tag, "_w_en"}, spad_w_en, 0);
    check({tag, "_w_addr"}, spad_w_addr, 0);
    check({tag, "_r_addr"}, spad_r_addr, 0);
    check({tag, "_din"}, spad_din, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Entered and left just after a posedge with the DUT idle.
  task automatic run_job(input int len_m1, input int pass_m1, input logic [3:0] rdy_pat, input bit gaps);
    int n_ent, n_tot, idx, e, k, guard, cyc, a, p;
    logic [DW-1:0] part [32];
    logic [DW-1:0] nxt;
    n_ent = len_m1 + 1;
    n_tot = n_ent * (pass_m1 + 1);
    start = 1'b1; cfg_len_m1 = AW'(len_m1); cfg_pass_m1 = PW'(pass_m1);
    prod_valid = 1'b1; prod_data = job_prods[0]; psum_out_ready = 1'b0;
    @(negedge clk); #1;
    check("idle_prod_ready", prod_ready, 0);
    check("idle_w_en", spad_w_en, 0);
    @(posedge clk); #1;
    start = 1'b0; cfg_len_m1 = '0; cfg_pass_m1 = '0;
    cyc = 1; idx = 0; guard = 0;
    while (idx < n_tot && guard < 1000) begin
      prod_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      prod_data  = prod_valid ? job_prods[idx] : 16'($urandom);
      @(negedge clk); #1;
      check("accum_ready", prod_ready, 1);
      check("accum_busy", busy, 1);
      check("accum_w_en", spad_w_en, prod_valid);
      if (prod_valid) begin
        a = idx % n_ent; p = idx / n_ent;
        nxt = acc_add((p == 0) ? '0 : part[a], prod_data);
        check("accum_w_addr", spad_w_addr, a);
        check("accum_r_addr", spad_r_addr, a);
        check("accum_din", spad_din, nxt);
        part[a] = nxt;
        idx++;
      end
      @(posedge clk); #1;
      cyc++; guard++;
    end
    check("accum_products_taken", idx, n_tot);
    prod_valid = 1'b0;
    e = 0; k = 0; guard = 0;
    while (e < n_ent && guard < 1000) begin
      psum_out_ready = rdy_pat[k % 4];
      k++;
      @(negedge clk); #1;
      check("drain_valid", psum_out_valid, 1);
      check("drain_prod_ready", prod_ready, 0);
      check("drain_w_en", spad_w_en, 0);
      check("drain_r_addr", spad_r_addr, e);
      check("drain_data", psum_out_data, job_exp[e]);
      if (psum_out_ready) e++;
      @(posedge clk); #1;
      cyc++; guard++;
    end
    check("drain_entries", e, n_ent);
    psum_out_ready = 1'b0;
    @(negedge clk); #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_out_valid", psum_out_valid, 0);
    if (!gaps && rdy_pat == 4'hF) check("job_cycles", cyc, 1 + n_tot + n_ent);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("done_clear", done, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int                  len_m1;
    int                  pass_m1;
    logic [7:0][DW-1:0]  prod;
    logic [3:0][DW-1:0]  exp;
    logic [3:0]          rdy;
  } vec_t;

  vec_t tbl [6];

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len_m1 = '0; cfg_pass_m1 = '0;
    prod_valid = 1'b0; prod_data = '0; psum_out_ready = 1'b0;

    tbl[0] = '{len_m1: 3, pass_m1: 0, prod: '{default: '0}, exp: '{default: '0}, rdy: 4'hF};
    tbl[0].prod[0] = 1; tbl[0].prod[1] = 2; tbl[0].prod[2] = 3; tbl[0].prod[3] = 4;
    tbl[0].exp[0] = 1;  tbl[0].exp[1] = 2;  tbl[0].exp[2] = 3;  tbl[0].exp[3] = 4;
    tbl[1] = '{len_m1: 1, pass_m1: 2, prod: '{default: '0}, exp: '{default: '0}, rdy: 4'hF};
    for (int i = 0; i < 6; i++) tbl[1].prod[i] = (i % 2 == 0) ? 16'd10 : 16'd20;
    tbl[1].exp[0] = 30; tbl[1].exp[1] = 60;
    tbl[2] = '{len_m1: 0, pass_m1: 3, prod: '{default: 16'd5}, exp: '{default: '0}, rdy: 4'hF};
    tbl[2].exp[0] = 20;
    tbl[3] = '{len_m1: 3, pass_m1: 0, prod: '{default: '0}, exp: '{default: '0}, rdy: 4'b1001};
    tbl[3].prod[0] = 7; tbl[3].prod[1] = 8; tbl[3].prod[2] = 9; tbl[3].prod[3] = 10;
    tbl[3].exp[0] = 7;  tbl[3].exp[1] = 8;  tbl[3].exp[2] = 9;  tbl[3].exp[3] = 10;
    tbl[4] = '{len_m1: 0, pass_m1: 1, prod: '{default: '0}, exp: '{default: '0}, rdy: 4'hF};
    tbl[4].prod[0] = 16'h7000; tbl[4].prod[1] = 16'h2000;
    tbl[5] = '{len_m1: 1, pass_m1: 1, prod: '{default: '0}, exp: '{default: '0}, rdy: 4'hF};
    tbl[5].prod[0] = 16'h8000; tbl[5].prod[1] = 16'h0001; tbl[5].prod[2] = 16'hFFFF; tbl[5].prod[3] = 16'h0002;
    tbl[5].exp[1] = 16'h0003;
`ifdef PSUM_ACC_SAT_EN
    tbl[4].exp[0] = PSUM_MAX;
    tbl[5].exp[0] = PSUM_MIN;
`else
    tbl[4].exp[0] = 16'h9000;
    tbl[5].exp[0] = 16'h7FFF;
`endif

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1; scramble = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle");

    foreach (tbl[t]) begin
      job_prods.delete(); job_exp.delete();
      for (int i = 0; i < (tbl[t].len_m1 + 1) * (tbl[t].pass_m1 + 1); i++) job_prods.push_back(tbl[t].prod[i]);
      for (int i = 0; i <= tbl[t].len_m1; i++) job_exp.push_back(tbl[t].exp[i]);
      run_job(tbl[t].len_m1, tbl[t].pass_m1, tbl[t].rdy, 1'b0);
    end

    // Abandon a job at addr 2, pass 1, then confirm the next job ignores stale spad data.
    start = 1'b1; cfg_len_m1 = 5'd3; cfg_pass_m1 = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; prod_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      prod_data = 16'($urandom_range(1, 16'hFFFF));
      @(posedge clk); #1;
    end
    check("mid_busy", busy, 1);
    check("mid_w_addr", spad_w_addr, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1; prod_valid = 1'b0;
    @(posedge clk); #1;
    job_prods = '{16'd11, 16'd22, 16'd33, 16'd44};
    job_exp   = '{16'd11, 16'd22, 16'd33, 16'd44};
    run_job(3, 0, 4'hF, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int len_m1, pass_m1;
      logic [DW-1:0] acc;
      len_m1 = $urandom_range(0, 5);
      pass_m1 = $urandom_range(0, 3);
      job_prods.delete(); job_exp.delete();
      for (int i = 0; i < (len_m1 + 1) * (pass_m1 + 1); i++) job_prods.push_back(16'($urandom));
      for (int a = 0; a <= len_m1; a++) begin
        acc = '0;
        for (int p = 0; p <= pass_m1; p++) acc = acc_add(acc, job_prods[p * (len_m1 + 1) + a]);
        job_exp.push_back(acc);
      end
      run_job(len_m1, pass_m1, 4'($urandom_range(1, 15)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
